kws_host_serial_link: RTL and testbench
=======================================

// Module: kws_host_serial_link
// PURPOSE
//  Host-side end of the kws_v3 serial interface. Accepts NUM_WORDS 64-bit words via valid/ready and shifts each out MSB-first
//  on the accelerator's serial load input. Pulses start_computation, waits for computation_done,
//  then deserializes the 64-bit result from the accelerator's serial output and presents it on a valid/ready port.
// PARAMETERS
//  WORD_W         64    bits per word; fixed by the accelerator load/result registers
//  NUM_WORDS      4     words per frame shifted in before start is pulsed (>=1)
//  TIMEOUT_CYCLES 4096  WAIT_DONE cycle limit; used only with KWS_LINK_TIMEOUT_EN
// PORTS
//  clk               in   1       single clock; all logic on rising edge
//  reset             in   1       synchronous, active-high
//  tx_data           in   WORD_W  frame word to send
//  tx_valid          in   1       tx_data valid
//  tx_ready          out  1       word accepted when tx_valid & tx_ready
//  rx_data           out  WORD_W  captured result, stable while rx_valid
//  rx_valid          out  1       result available; held until rx_ready
//  rx_ready          in   1       result consumed when rx_valid & rx_ready
//  busy              out  1       high in any state except IDLE
//  err_timeout       out  1       sticky done-timeout flag (macro-dependent)
//  link_sdata_out    out  1       to accelerator serial_data_in; registered
//  link_load_en      out  1       to accelerator serial_load_enable; registered
//  link_start        out  1       to accelerator start_computation; 1-cycle pulse
//  link_sdata_in     in   1       from accelerator serial_data_out
//  link_done         in   1       from accelerator computation_done (level, may stay high)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs, shift regs, counters, done_q = 0. Reset mid-frame aborts silently; no partial result.
//  FSM: IDLE -> SHIFT -> START -> WAIT_DONE -> CAPTURE -> DELIVER -> IDLE.
//  IDLE: tx_ready=1. On accept, load tx_sh, bit_cnt=0, word_cnt=0 -> SHIFT.
//  SHIFT: link_load_en=1, link_sdata_out=tx_sh[63]; tx_sh<<=1 each cycle.
//   Accepted at edge N: bits 63..0 appear on cycles N+1..N+64.
//   bit_cnt==63 and word_cnt<NUM_WORDS-1: tx_ready=1 (combinational).
//   If accepted, reload and continue with no gap. Else stall: load_en=0, wait in SHIFT for tx_valid.
//   bit_cnt==63 on last word -> START; word_cnt and bit_cnt wrap to 0.
//  START: one cycle link_start=1, link_load_en=0 -> WAIT_DONE.
//  WAIT_DONE: done_q<=link_done every cycle in all states.
//   Trigger only on rising edge (link_done & ~done_q) seen in WAIT_DONE. A level held high from a prior frame does not trigger.
//   On trigger, sample link_sdata_in as bit 63 in the same cycle -> CAPTURE.
//  CAPTURE: rx_sh<={rx_sh[62:0],link_sdata_in}, 63 further cycles (64 samples total, MSB-first).
//   After the 64th sample: rx_data<=rx_sh, rx_valid=1 -> DELIVER.
//  DELIVER: rx_data and rx_valid held until rx_ready. tx_ready=0 here. Accept -> IDLE; rx_valid=0 next cycle.
//  Simultaneous: rx_ready with rx_valid in the entry cycle is honoured; minimum DELIVER residency is 1 cycle.
//  tx_valid is ignored outside IDLE and the SHIFT reload slot.
// CONFIGURATION
//  KWS_LINK_TIMEOUT_EN defined:
//   wait_cnt counts WAIT_DONE cycles. At TIMEOUT_CYCLES: err_timeout<=1 -> IDLE, no rx_valid.
//   err_timeout clears on the next accepted tx word.
//  Not defined: no wait_cnt. err_timeout tied 0. WAIT_DONE waits indefinitely.
// STRUCTURE
//  kws_link_pkg: WORD_W, state encoding (IDLE..DELIVER), default TIMEOUT_CYCLES, counter widths (6-bit bit_cnt).
//  One sub-module kws_link_shreg: parameterised 64-bit shift register with load, shift enable,
//   serial in/out and parallel in/out. Instantiated twice: TX PISO and RX SIPO.
// TESTING
//  Model: behavioural accelerator. 64-bit left-shift load reg (LSB in). Sticky done. Result shifts out MSB-first from done.
//  NUM_WORDS=1, tx=64'hDEAD_BEEF_0123_4567 -> load_en high 64 cycles; model reg==tx;
//   link_start 1 cycle after last bit.
//  NUM_WORDS=4, tx_valid continuous -> load_en high 256 consecutive cycles; tx_ready pulses 3 times mid-frame.
//  tx_valid dropped 10 cycles between words 1 and 2 -> load_en low exactly 10 cycles; model words intact.
//  Model result 64'h8000_0000_0000_0001, rx_ready=0 for 5 cycles -> rx_data stable, rx_valid held; then IDLE.
//  Second frame without model reset (done stays high) -> no capture.
//   With macro: err_timeout after 4096 cycles, busy=0.
//  reset asserted mid-SHIFT (bit 20) -> next cycle all outputs 0, IDLE; fresh frame completes correctly.

Source files
------------

// File: rtl/kws_link_pkg.sv
// kws_link_pkg: shared widths, defaults and FSM encoding
// for the kws_v3 host serial link.
package kws_link_pkg;

   localparam int WORD_W          = 64;
   localparam int BIT_CNT_W       = 6;
   localparam int TIMEOUT_DEFAULT = 4096;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SHIFT   = 3'd1;
   localparam logic [2:0] ST_START   = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_CAPTURE = 3'd4;
   localparam logic [2:0] ST_DELIVER = 3'd5;

endpackage

// File: rtl/kws_link_shreg.sv
// kws_link_shreg: parallel-load, left-shifting register
// with serial in/out; used as both TX PISO and RX SIPO.
module kws_link_shreg
   import kws_link_pkg::*;
#(
   parameter int W = WORD_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic         sin_i,
   input  logic [W-1:0] pin_i,
   output logic [W-1:0] pout_o,
   output logic         sout_o
);

   logic [W-1:0] sh_q;
   logic [W-1:0] sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load_i) begin
         sh_d = pin_i;
      end else if (shift_i) begin
         sh_d = {sh_q[W-2:0], sin_i};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign pout_o = sh_q;
   assign sout_o = sh_q[W-1];

endmodule

// File: rtl/kws_host_serial_link.sv
// kws_host_serial_link: host side of the kws_v3 serial link.
// Optional done-timeout enabled by defining KWS_LINK_TIMEOUT_EN.
module kws_host_serial_link
   import kws_link_pkg::*;
#(
   parameter int NUM_WORDS      = 4,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              err_timeout,
   output logic              link_sdata_out,
   output logic              link_load_en,
   output logic              link_start,
   input  logic              link_sdata_in,
   input  logic              link_done
);

   localparam int WCNT_W =
      (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [WCNT_W-1:0] LAST_WORD =
      WCNT_W'(NUM_WORDS - 1);

   logic [2:0]           state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
   logic                 load_en_q, load_en_d;
   logic                 start_q, start_d;
   logic                 rx_valid_q, rx_valid_d;
   logic [WORD_W-1:0]    rx_data_q, rx_data_d;
   logic                 done_q;

   logic              tx_load, tx_shift, rx_shift;
   logic              tx_acc, last_bit, last_word;
   logic              done_rise, timeout_hit;
   logic [WORD_W-1:0] tx_pout, rx_pout;
   logic              rx_sout;

   assign last_bit  = (bit_cnt_q == BIT_CNT_W'(WORD_W - 1));
   assign last_word = (word_cnt_q == LAST_WORD);
   assign done_rise = link_done & ~done_q;

   // Reload slot on the last bit of a non-final word, or
   // any cycle of a stall waiting for the next word.
   assign tx_ready =
      (state_q == ST_IDLE) |
      ((state_q == ST_SHIFT) &
       (~load_en_q | (last_bit & ~last_word)));
   assign tx_acc = tx_valid & tx_ready;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      load_en_d  = load_en_q;
      start_d    = 1'b0;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      tx_load    = 1'b0;
      tx_shift   = 1'b0;
      rx_shift   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_acc) begin
               tx_load    = 1'b1;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               load_en_d  = 1'b1;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (load_en_q) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (!last_bit) begin
                  tx_shift = 1'b1;
               end else if (last_word) begin
                  tx_shift   = 1'b1;
                  load_en_d  = 1'b0;
                  word_cnt_d = '0;
                  start_d    = 1'b1;
                  state_d    = ST_START;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
                  if (tx_acc) begin
                     tx_load = 1'b1;
                  end else begin
                     tx_shift  = 1'b1;
                     load_en_d = 1'b0;
                  end
               end
            end else if (tx_acc) begin
               tx_load   = 1'b1;
               load_en_d = 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_rise) begin
               rx_shift  = 1'b1;
               bit_cnt_d = '0;
               state_d   = ST_CAPTURE;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            rx_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_CNT_W'(WORD_W - 2)) begin
               bit_cnt_d  = '0;
               rx_data_d  = {rx_pout[WORD_W-2:0], link_sdata_in};
               rx_valid_d = 1'b1;
               state_d    = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            if (rx_ready) begin
               rx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         load_en_q  <= 1'b0;
         start_q    <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         load_en_q  <= load_en_d;
         start_q    <= start_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         done_q     <= link_done;
      end
   end

`ifdef KWS_LINK_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;

   assign timeout_hit = (state_q == ST_WAIT) & ~done_rise &
      (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_cnt_d = '0;
      if (state_q == ST_WAIT) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      err_d = err_q;
      if (timeout_hit) begin
         err_d = 1'b1;
      end else if (tx_acc) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   assign err_timeout = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

   kws_link_shreg #(.W(WORD_W)) u_tx_sh (
      .clk     (clk),
      .reset   (reset),
      .load_i  (tx_load),
      .shift_i (tx_shift),
      .sin_i   (1'b0),
      .pin_i   (tx_data),
      .pout_o  (tx_pout),
      .sout_o  (link_sdata_out)
   );

   kws_link_shreg #(.W(WORD_W)) u_rx_sh (
      .clk     (clk),
      .reset   (reset),
      .load_i  (1'b0),
      .shift_i (rx_shift),
      .sin_i   (link_sdata_in),
      .pin_i   ('0),
      .pout_o  (rx_pout),
      .sout_o  (rx_sout)
   );

   logic unused_ok;
   assign unused_ok =
      ^{tx_pout, rx_sout, rx_pout[WORD_W-1], TIMEOUT_CYCLES[0]};

   assign link_load_en = load_en_q;
   assign link_start   = start_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_kws_host_serial_link.sv
// tb_kws_host_serial_link: directed bench with a behavioural
// kws_v3 accelerator model on the serial side.
module tb_kws_host_serial_link;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [63:0] rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        busy;
   logic        err_timeout;
   logic        link_sdata_out;
   logic        link_load_en;
   logic        link_start;
   logic        link_sdata_in;
   logic        link_done;

   int checks = 0;
   int errors = 0;

   logic [63:0]  fw [4];
   logic [255:0] m_load;
   logic [63:0]  m_out;
   logic [63:0]  m_result = '0;
   logic         m_done;
   logic         m_armed;
   int           m_cnt;
   logic         m_clr = 1'b1;

   always #5 clk = ~clk;

   kws_host_serial_link #(
      .NUM_WORDS      (4),
      .TIMEOUT_CYCLES (4096)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .busy           (busy),
      .err_timeout    (err_timeout),
      .link_sdata_out (link_sdata_out),
      .link_load_en   (link_load_en),
      .link_start     (link_start),
      .link_sdata_in  (link_sdata_in),
      .link_done      (link_done)
   );

   // Accelerator: shift-in load reg, sticky done, result
   // presented MSB-first starting in the cycle done rises.
   always @(posedge clk) begin
      if (m_clr) begin
         m_load  <= '0;
         m_out   <= '0;
         m_done  <= 1'b0;
         m_armed <= 1'b0;
         m_cnt   <= 0;
      end else begin
         if (link_load_en)
            m_load <= {m_load[254:0], link_sdata_out};
         if (m_done)
            m_out <= m_out << 1;
         if (link_start && !m_done) begin
            m_armed <= 1'b1;
            m_cnt   <= 5;
         end else if (m_armed) begin
            if (m_cnt == 0) begin
               m_armed <= 1'b0;
               m_done  <= 1'b1;
               m_out   <= m_result;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   assign link_done     = m_done;
   assign link_sdata_in = m_out[63];

   task automatic clear_model();
      m_clr = 1'b1;
      @(posedge clk); #1;
      m_clr = 1'b0;
   endtask

   task automatic run_frame(input int gap, output int hi,
      output int lo, output int rdy, output bit start_ok,
      output bit start_seen);
      int  idx, gleft;
      bit  acc, gon, prev_le;
      idx = 0; gleft = gap; gon = 0; acc = 0; prev_le = 0;
      hi = 0; lo = 0; rdy = 0; start_ok = 0; start_seen = 0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         if (acc) idx++;
         if (link_start) begin
            start_ok = prev_le;
            start_seen = 1;
            break;
         end
         if (link_load_en) hi++;
         else if (hi > 0) lo++;
         if (tx_ready && link_load_en) rdy++;
         prev_le = link_load_en;
         if (idx == 2 && gleft > 0 && (tx_ready || gon)) begin
            gon = 1;
            gleft--;
            tx_valid = 1'b0;
         end else if (idx < 4) begin
            tx_valid = 1'b1;
            tx_data = fw[idx];
         end else begin
            tx_valid = 1'b0;
         end
         acc = tx_valid && tx_ready;
      end
      tx_valid = 1'b0;
   endtask

   task automatic get_result(input int hold, output bit got,
      output logic [63:0] d, output bit held_ok,
      output bit after_ok);
      got = 0; held_ok = 1; after_ok = 0; d = '0;
      rx_ready = (hold == 0);
      for (int n = 0; n < 400 && !got; n++) begin
         @(posedge clk); #1;
         got = rx_valid;
      end
      if (got) begin
         d = rx_data;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rx_valid !== 1'b1 || rx_data !== d) held_ok = 0;
         end
         rx_ready = 1'b1;
         @(posedge clk); #1;
         after_ok = ({rx_valid, busy, tx_ready} === 3'b001);
      end
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, rx_valid, err_timeout, link_load_en,
           link_start, link_sdata_out} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outs got %b want 000000",
            {busy, rx_valid, err_timeout, link_load_en,
             link_start, link_sdata_out});
      end
      checks++;
      if (rx_data !== 64'h0) begin
         errors++;
         $display("FAIL reset_rx_data got %h want 0", rx_data);
      end
      checks++;
      if (tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx_ready got %b want 1", tx_ready);
      end
      reset = 1'b0;
      m_clr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_frame_continuous();
      int hi, lo, rdy;
      bit sok, sseen, got, held, after;
      logic [63:0] d;
      fw[0] = 64'hDEAD_BEEF_0123_4567;
      fw[1] = 64'h0123_4567_89AB_CDEF;
      fw[2] = 64'hFFFF_0000_FFFF_0000;
      fw[3] = 64'h1357_9BDF_2468_ACE0;
      m_result = 64'h8000_0000_0000_0001;
      run_frame(0, hi, lo, rdy, sok, sseen);
      checks++;
      if (hi != 256 || lo != 0) begin
         errors++;
         $display("FAIL cont_load_en got hi=%0d lo=%0d want 256/0",
            hi, lo);
      end
      checks++;
      if (rdy != 3) begin
         errors++;
         $display("FAIL cont_ready_pulses got %0d want 3", rdy);
      end
      checks++;
      if (!sseen || !sok) begin
         errors++;
         $display("FAIL cont_start got seen=%0d after_bit=%0d want 1/1",
            sseen, sok);
      end
      @(posedge clk); #1;
      checks++;
      if (link_start !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL cont_start_width got start=%b busy=%b want 0/1",
            link_start, busy);
      end
      checks++;
      if (m_load !== {fw[0], fw[1], fw[2], fw[3]}) begin
         errors++;
         $display("FAIL cont_model_load got %h want %h",
            m_load, {fw[0], fw[1], fw[2], fw[3]});
      end
      get_result(5, got, d, held, after);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL cont_rx_valid got 0 want 1");
      end
      checks++;
      if (d !== 64'h8000_0000_0000_0001) begin
         errors++;
         $display("FAIL cont_rx_data got %h want 8000000000000001", d);
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL cont_rx_hold got unstable want stable");
      end
      checks++;
      if (!after) begin
         errors++;
         $display("FAIL cont_deliver_exit got v/b/r=%b%b%b want 001",
            rx_valid, busy, tx_ready);
      end
   endtask

   task automatic test_stall();
      int hi, lo, rdy;
      bit sok, sseen, got, held, after;
      logic [63:0] d;
      clear_model();
      fw[0] = 64'hA5A5_A5A5_5A5A_5A5A;
      fw[1] = 64'h0000_0000_0000_0001;
      fw[2] = 64'h8000_0000_0000_0000;
      fw[3] = 64'hCAFE_F00D_BAAD_D00D;
      m_result = 64'hA5A5_0F0F_1234_FEDC;
      run_frame(10, hi, lo, rdy, sok, sseen);
      checks++;
      if (hi != 256 || lo != 10) begin
         errors++;
         $display("FAIL stall_load_en got hi=%0d lo=%0d want 256/10",
            hi, lo);
      end
      checks++;
      if (!sseen || !sok || rdy != 3) begin
         errors++;
         $display("FAIL stall_start got seen=%0d ok=%0d rdy=%0d want 1/1/3",
            sseen, sok, rdy);
      end
      checks++;
      if (m_load !== {fw[0], fw[1], fw[2], fw[3]}) begin
         errors++;
         $display("FAIL stall_model_load got %h want %h",
            m_load, {fw[0], fw[1], fw[2], fw[3]});
      end
      get_result(0, got, d, held, after);
      checks++;
      if (!got || d !== 64'hA5A5_0F0F_1234_FEDC) begin
         errors++;
         $display("FAIL stall_rx_data got v=%0d %h want 1 a5a50f0f1234fedc",
            got, d);
      end
      checks++;
      if (!after) begin
         errors++;
         $display("FAIL stall_entry_accept got v/b/r=%b%b%b want 001",
            rx_valid, busy, tx_ready);
      end
   endtask

   task automatic test_sticky_done();
      int hi, lo, rdy, n;
      bit sok, sseen, saw_rx;
      m_result = 64'hFFFF_FFFF_FFFF_FFFF;
      run_frame(0, hi, lo, rdy, sok, sseen);
      checks++;
      if (!sseen) begin
         errors++;
         $display("FAIL sticky_start got 0 want 1");
      end
      saw_rx = 0;
`ifdef KWS_LINK_TIMEOUT_EN
      n = 0;
      for (int c = 0; c < 4200 && busy; c++) begin
         @(posedge clk); #1;
         n++;
         if (rx_valid) saw_rx = 1;
      end
      checks++;
      if (n != 4097 || busy !== 1'b0 || err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL sticky_timeout got n=%0d busy=%b err=%b want 4097/0/1",
            n, busy, err_timeout);
      end
      tx_data = 64'h1;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL err_clear got err=%b busy=%b want 0/1",
            err_timeout, busy);
      end
`else
      n = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         n++;
         if (rx_valid) saw_rx = 1;
      end
      checks++;
      if (busy !== 1'b1 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL sticky_wait got busy=%b err=%b want 1/0",
            busy, err_timeout);
      end
`endif
      checks++;
      if (saw_rx) begin
         errors++;
         $display("FAIL sticky_no_capture got rx_valid=1 want 0");
      end
   endtask

   task automatic test_reset_mid_shift();
      int hi, lo, rdy, cnt;
      bit sok, sseen, got, held, after;
      logic [63:0] d;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      clear_model();
      tx_data = 64'hFEED_FACE_0BAD_F00D;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      cnt = 0;
      for (int c = 0; c < 100 && cnt < 21; c++) begin
         if (link_load_en) cnt++;
         if (cnt < 21) begin
            @(posedge clk); #1;
         end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, rx_valid, err_timeout, link_load_en,
           link_start, link_sdata_out, tx_ready} !== 7'b0000001) begin
         errors++;
         $display("FAIL midreset_outs got %b want 0000001",
            {busy, rx_valid, err_timeout, link_load_en,
             link_start, link_sdata_out, tx_ready});
      end
      reset = 1'b0;
      clear_model();
      fw[0] = 64'h0F1E_2D3C_4B5A_6978;
      fw[1] = 64'h8796_A5B4_C3D2_E1F0;
      fw[2] = 64'h5555_AAAA_5555_AAAA;
      fw[3] = 64'hDEAD_BEEF_0123_4567;
      m_result = 64'h0123_4567_89AB_CDEF;
      run_frame(0, hi, lo, rdy, sok, sseen);
      checks++;
      if (!sseen || hi != 256 ||
          m_load !== {fw[0], fw[1], fw[2], fw[3]}) begin
         errors++;
         $display("FAIL fresh_frame got seen=%0d hi=%0d load=%h want 1/256/%h",
            sseen, hi, m_load, {fw[0], fw[1], fw[2], fw[3]});
      end
      get_result(2, got, d, held, after);
      checks++;
      if (!got || d !== 64'h0123_4567_89AB_CDEF || !held || !after) begin
         errors++;
         $display("FAIL fresh_result got v=%0d %h h=%0d a=%0d want 1 0123456789abcdef 1 1",
            got, d, held, after);
      end
   endtask

   initial begin
      test_reset();
      test_frame_continuous();
      test_stall();
      test_sticky_done();
      test_reset_mid_shift();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
